// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S/TDM serial audio transmitter.
// Build option: I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun counter output.
package i2s_pkg;

   typedef enum logic {I2S_MODE_PHILIPS, I2S_MODE_LJ} i2s_mode_e;

   typedef enum logic {ST_IDLE, ST_RUN} tx_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int frame_bits(input int n_ch, input int slot_w);
      return n_ch * slot_w;
   endfunction

endpackage

// File: rtl/i2s_tdm_tx_bclk_gen.sv
// i2s_bclk_gen: clk-domain divider that produces the bit clock as a register
// plus single-cycle strobes marking the cycles where bclk rises or falls.
module i2s_bclk_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV_HALF = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic stop,
   output logic bclk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int DW = clog2(CLK_DIV_HALF + 1);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV_HALF - 1);

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick     = run && (div_cnt == LAST);
   assign rise_stb = tick && !bclk;
   assign fall_stb = tick && bclk;

   always_ff @(posedge clk) begin
      if (reset || stop) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (run) begin
         if (tick) begin
            div_cnt <= '0;
            bclk    <= !bclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: frame FIFO plus MSB-first I2S/TDM serialiser, fully in the clk domain.
// Build option: I2S_TX_UNDERRUN_CNT_EN adds output underrun_cnt[15:0].
module i2s_tdm_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV_HALF = 4,
   parameter int SAMPLE_W     = 16,
   parameter int SLOT_W       = 16,
   parameter int N_CH         = 2,
   parameter int FIFO_DEPTH   = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     mode,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [N_CH*SAMPLE_W-1:0] s_data,
   output logic                     bclk,
   output logic                     lrclk,
   output logic                     sdata,
   output logic                     underrun,
`ifdef I2S_TX_UNDERRUN_CNT_EN
   output logic [15:0]              underrun_cnt,
`endif
   output logic                     busy
);

   localparam int DW = N_CH * SAMPLE_W;
   localparam int FB = frame_bits(N_CH, SLOT_W);
   localparam int AW = clog2(FIFO_DEPTH);
   localparam int BW = clog2(SLOT_W + 1);
   localparam int CW = clog2(N_CH + 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(N_CH - 1);

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [DW-1:0] fifo_q;

   tx_state_e     state_q, state_d;
   i2s_mode_e     mode_q, mode_nxt;
   logic [FB-1:0] shreg, fmt;
   logic [BW-1:0] bit_cnt, nb;
   logic [CW-1:0] slot_cnt, ns;
   logic          lj_prev, lj_bit, lr_nxt;
   logic          load, go_idle, step, frame_end;
   logic          fall_stb, unused_rise;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign s_ready = !reset && !full;
   assign push    = s_valid && s_ready;
   assign pop     = load && !empty;
   assign fifo_q  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= s_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   i2s_bclk_gen #(
      .CLK_DIV_HALF(CLK_DIV_HALF)
   ) u_bclk (
      .clk     (clk),
      .reset   (reset),
      .run     (state_q == ST_RUN),
      .stop    (go_idle),
      .bclk    (bclk),
      .rise_stb(unused_rise),
      .fall_stb(fall_stb)
   );

   assign frame_end = fall_stb && (bit_cnt == BIT_LAST)
                      && (slot_cnt == SLOT_LAST);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      go_idle = 1'b0;
      unique case (state_q)
         ST_IDLE: if (enable) begin
            state_d = ST_RUN;
            load    = 1'b1;
         end
         ST_RUN: if (frame_end) begin
            if (enable) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
               go_idle = 1'b1;
            end
         end
      endcase
   end

   // Slot-formatted frame: ch0 at the top, each sample followed by zero padding
   always_comb begin
      fmt = '0;
      for (int k = 0; k < N_CH; k++)
         fmt[FB-1-k*SLOT_W -: SAMPLE_W] = fifo_q[k*SAMPLE_W +: SAMPLE_W];
   end

   always_comb begin
      nb = '0;
      ns = '0;
      if (!load) begin
         if (bit_cnt == BIT_LAST) begin
            ns = slot_cnt + 1'b1;
         end else begin
            nb = bit_cnt + 1'b1;
            ns = slot_cnt;
         end
      end
   end

   assign step     = load || (fall_stb && !go_idle);
   assign mode_nxt = load ? i2s_mode_e'(mode) : mode_q;
   assign lj_bit   = load ? fmt[FB-1] : shreg[FB-1];

   always_comb begin
      if (N_CH == 2)
         lr_nxt = (ns == CW'(1));
      else if (mode_nxt == I2S_MODE_LJ)
         lr_nxt = (ns == '0) && (nb == '0);
      else
         lr_nxt = (ns == SLOT_LAST) && (nb == BIT_LAST);
   end

   // lj_prev carries the previous bit so PHILIPS runs one bclk behind LJ
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mode_q   <= I2S_MODE_PHILIPS;
         shreg    <= '0;
         bit_cnt  <= '0;
         slot_cnt <= '0;
         lj_prev  <= 1'b0;
         sdata    <= 1'b0;
         lrclk    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state_q  <= state_d;
         underrun <= load && empty;
         if (go_idle) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
            lj_prev  <= 1'b0;
            sdata    <= 1'b0;
            lrclk    <= 1'b0;
         end else if (step) begin
            bit_cnt  <= nb;
            slot_cnt <= ns;
            mode_q   <= mode_nxt;
            shreg    <= load ? {fmt[FB-2:0], 1'b0} : {shreg[FB-2:0], 1'b0};
            lj_prev  <= lj_bit;
            sdata    <= (mode_nxt == I2S_MODE_LJ) ? lj_bit : lj_prev;
            lrclk    <= lr_nxt;
         end
      end
   end

   assign busy = (state_q == ST_RUN);

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         underrun_cnt <= '0;
      else if (underrun && (underrun_cnt != 16'hFFFF))
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: stereo and TDM instances driven with random frames and
// compared bit-by-bit against a frame-level model of the serial stream.
`timescale 1ns/1ps
module tb_i2s_tdm_tx;

   localparam int A_NCH = 2;
   localparam int A_SW  = 16;
   localparam int A_SLW = 16;
   localparam int A_FB  = 32;
   localparam int B_NCH = 4;
   localparam int B_SW  = 12;
   localparam int B_SLW = 16;
   localparam int B_FB  = 64;

   typedef logic [1:0]  cap_t;
   typedef logic [63:0] frm_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset, a_enable, a_mode, a_s_valid, a_s_ready;
   logic [31:0] a_s_data;
   logic        a_bclk, a_lrclk, a_sdata, a_underrun, a_busy;
   logic        b_reset, b_enable, b_mode, b_s_valid, b_s_ready;
   logic [47:0] b_s_data;
   logic        b_bclk, b_lrclk, b_sdata, b_underrun, b_busy;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] a_ucnt, b_ucnt;
`endif

   i2s_tdm_tx #(
      .CLK_DIV_HALF(2), .SAMPLE_W(A_SW), .SLOT_W(A_SLW),
      .N_CH(A_NCH), .FIFO_DEPTH(4)
   ) dut_a (
      .clk(clk), .reset(a_reset), .enable(a_enable), .mode(a_mode),
      .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
      .bclk(a_bclk), .lrclk(a_lrclk), .sdata(a_sdata),
      .underrun(a_underrun),
`ifdef I2S_TX_UNDERRUN_CNT_EN
      .underrun_cnt(a_ucnt),
`endif
      .busy(a_busy)
   );

   i2s_tdm_tx #(
      .CLK_DIV_HALF(2), .SAMPLE_W(B_SW), .SLOT_W(B_SLW),
      .N_CH(B_NCH), .FIFO_DEPTH(4)
   ) dut_b (
      .clk(clk), .reset(b_reset), .enable(b_enable), .mode(b_mode),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
      .bclk(b_bclk), .lrclk(b_lrclk), .sdata(b_sdata),
      .underrun(b_underrun),
`ifdef I2S_TX_UNDERRUN_CNT_EN
      .underrun_cnt(b_ucnt),
`endif
      .busy(b_busy)
   );

   int nchk = 0;
   int nfail = 0;

   cap_t cap_a[$];
   cap_t cap_b[$];
   int   ur_a = 0;
   int   ur_b = 0;
   logic pa = 1'b0;
   logic pb = 1'b0;

   // Receiver view: {lrclk, sdata} sampled once per bclk rise
   always @(negedge clk) begin
      if (a_bclk === 1'b1 && pa === 1'b0) cap_a.push_back({a_lrclk, a_sdata});
      if (b_bclk === 1'b1 && pb === 1'b0) cap_b.push_back({b_lrclk, b_sdata});
      if (a_underrun === 1'b1) ur_a <= ur_a + 1;
      if (b_underrun === 1'b1) ur_b <= ur_b + 1;
      pa <= a_bclk;
      pb <= b_bclk;
   end

   // Stream bit g of consecutive frames (ch0 first, MSB first, zero pad)
   function automatic logic model_bit(input frm_t fr[$], input int g,
                                      input int fb, input int sw, input int slw);
      int p, slot, b;
      frm_t f;
      if (g < 0) return 1'b0;
      f    = fr[g / fb];
      p    = g % fb;
      slot = p / slw;
      b    = p % slw;
      if (b >= sw) return 1'b0;
      return f[slot*sw + sw - 1 - b];
   endfunction

   function automatic frm_t exp_data(input frm_t fr[$], input int k, input logic lj,
                                     input int fb, input int sw, input int slw);
      frm_t v;
      v = '0;
      for (int j = 0; j < fb; j++)
         v[fb-1-j] = model_bit(fr, k*fb + j - (lj ? 0 : 1), fb, sw, slw);
      return v;
   endfunction

   function automatic frm_t exp_lr(input logic lj, input int nch,
                                   input int fb, input int slw);
      frm_t v;
      v = '0;
      for (int j = 0; j < fb; j++)
         if (nch == 2)  v[fb-1-j] = (j / slw == 1);
         else if (lj)   v[fb-1-j] = (j == 0);
         else           v[fb-1-j] = (j == fb - 1);
      return v;
   endfunction

   function automatic frm_t got_word(input int sel, input int base, input int k,
                                     input int fb, input int bitsel);
      frm_t v;
      cap_t c;
      v = '0;
      for (int j = 0; j < fb; j++) begin
         c = (sel == 0) ? cap_a[base + k*fb + j] : cap_b[base + k*fb + j];
         v[fb-1-j] = c[bitsel];
      end
      return v;
   endfunction

   task automatic wait_caps(input int sel, input int n, input string nm);
      int t = 0;
      while (((sel == 0) ? cap_a.size() : cap_b.size()) < n && t < 20000) begin
         @(negedge clk); #1; t++;
      end
      nchk++;
      if (((sel == 0) ? cap_a.size() : cap_b.size()) < n) begin
         nfail++;
         $display("FAIL %s timeout: rises %0d required %0d", nm,
                  (sel == 0) ? cap_a.size() : cap_b.size(), n);
      end
   endtask

   task automatic wait_idle(input int sel, input string nm);
      int t = 0;
      while (((sel == 0) ? a_busy : b_busy) && t < 2000) begin
         @(negedge clk); t++;
      end
      nchk++;
      if ((sel == 0) ? a_busy : b_busy) begin
         nfail++;
         $display("FAIL %s busy_stuck: busy 1 required 0", nm);
      end
      @(negedge clk);
   endtask

   task automatic push_a(input frm_t d, output bit ok);
      int t = 0;
      @(negedge clk);
      a_s_data  = d[31:0];
      a_s_valid = 1'b1;
      while (!a_s_ready && t < 200) begin @(negedge clk); t++; end
      ok = a_s_ready;
      @(posedge clk);
      #1 a_s_valid = 1'b0;
   endtask

   task automatic push_b(input frm_t d, output bit ok);
      int t = 0;
      @(negedge clk);
      b_s_data  = d[47:0];
      b_s_valid = 1'b1;
      while (!b_s_ready && t < 200) begin @(negedge clk); t++; end
      ok = b_s_ready;
      @(posedge clk);
      #1 b_s_valid = 1'b0;
   endtask

   task automatic reset_a();
      @(negedge clk);
      a_reset = 1'b1; a_enable = 1'b0; a_s_valid = 1'b0;
      repeat (2) @(negedge clk);
      a_reset = 1'b0;
   endtask

   task automatic reset_b();
      @(negedge clk);
      b_reset = 1'b1; b_enable = 1'b0; b_s_valid = 1'b0;
      repeat (2) @(negedge clk);
      b_reset = 1'b0;
   endtask

   function automatic frm_t rnd_frame(input int bits);
      frm_t f;
      f = {$urandom, $urandom};
      return (bits == 64) ? f : (f & ((64'd1 << bits) - 64'd1));
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      nchk++;
      if ({a_bclk, a_lrclk, a_sdata, a_underrun, a_busy, a_s_ready} !== 6'b0) begin
         nfail++;
         $display("FAIL reset_outs_a: got %b required 000000",
                  {a_bclk, a_lrclk, a_sdata, a_underrun, a_busy, a_s_ready});
      end
      nchk++;
      if ({b_bclk, b_lrclk, b_sdata, b_underrun, b_busy, b_s_ready} !== 6'b0) begin
         nfail++;
         $display("FAIL reset_outs_b: got %b required 000000",
                  {b_bclk, b_lrclk, b_sdata, b_underrun, b_busy, b_s_ready});
      end
      a_reset = 1'b0;
      b_reset = 1'b0;
      @(negedge clk);
      nchk++;
      if ({a_s_ready, b_s_ready, a_busy, b_busy} !== 4'b1100) begin
         nfail++;
         $display("FAIL reset_release: ready/busy %b required 1100",
                  {a_s_ready, b_s_ready, a_busy, b_busy});
      end
   endtask

   task automatic run_stereo(input logic lj, input int nfr, input string nm);
      frm_t fr[$];
      bit   ok;
      int   base, ub;
      frm_t fixed;
      fixed = 64'h0F5AA5F0;
      a_mode = lj;
      fr.push_back(fixed);
      for (int i = 1; i < nfr; i++) fr.push_back(rnd_frame(32));
      for (int i = 0; i < nfr; i++) begin
         push_a(fr[i], ok);
         nchk++;
         if (!ok) begin nfail++; $display("FAIL %s push %0d: ready 0 required 1", nm, i); end
      end
      base = cap_a.size();
      ub   = ur_a;
      @(negedge clk);
      a_enable = 1'b1;
      wait_caps(0, base + nfr*A_FB, nm);
      a_enable = 1'b0;
      wait_idle(0, nm);
      for (int k = 0; k < nfr; k++) begin
         nchk++;
         if (got_word(0, base, k, A_FB, 0) !== exp_data(fr, k, lj, A_FB, A_SW, A_SLW)) begin
            nfail++;
            $display("FAIL %s data frame %0d: got %h required %h", nm, k,
                     got_word(0, base, k, A_FB, 0), exp_data(fr, k, lj, A_FB, A_SW, A_SLW));
         end
         nchk++;
         if (got_word(0, base, k, A_FB, 1) !== exp_lr(lj, A_NCH, A_FB, A_SLW)) begin
            nfail++;
            $display("FAIL %s lrclk frame %0d: got %h required %h", nm, k,
                     got_word(0, base, k, A_FB, 1), exp_lr(lj, A_NCH, A_FB, A_SLW));
         end
      end
      nchk++;
      if (got_word(0, base, 0, A_FB, 0) !== (lj ? 64'hA5F00F5A : 64'h52F807AD)) begin
         nfail++;
         $display("FAIL %s first_frame: got %h required %h", nm,
                  got_word(0, base, 0, A_FB, 0), lj ? 64'hA5F00F5A : 64'h52F807AD);
      end
      nchk++;
      if (got_word(0, base, 0, A_FB, 1) !== 64'h0000FFFF) begin
         nfail++;
         $display("FAIL %s first_lrclk: got %h required 0000ffff", nm,
                  got_word(0, base, 0, A_FB, 1));
      end
      nchk++;
      if (cap_a.size() - base != nfr*A_FB || ur_a != ub) begin
         nfail++;
         $display("FAIL %s rises/underruns: got %0d/%0d required %0d/0", nm,
                  cap_a.size() - base, ur_a - ub, nfr*A_FB);
      end
      nchk++;
      if ({a_bclk, a_lrclk, a_sdata, a_busy} !== 4'b0) begin
         nfail++;
         $display("FAIL %s stop_state: got %b required 0000", nm,
                  {a_bclk, a_lrclk, a_sdata, a_busy});
      end
   endtask

   task automatic test_lj();
      run_stereo(1'b1, 3, "lj");
   endtask

   task automatic test_philips();
      run_stereo(1'b0, 3, "philips");
   endtask

   task automatic test_underrun();
      frm_t fr[$];
      bit   ok;
      int   base, ub;
      reset_a();
      a_mode = 1'b1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      nchk++;
      if (a_ucnt !== 16'd0) begin
         nfail++; $display("FAIL ucnt_reset: got %0d required 0", a_ucnt);
      end
`endif
      fr.push_back(rnd_frame(32));
      fr.push_back(64'd0);
      push_a(fr[0], ok);
      base = cap_a.size();
      ub   = ur_a;
      @(negedge clk);
      a_enable = 1'b1;
      wait_caps(0, base + 2*A_FB, "underrun");
      a_enable = 1'b0;
      wait_idle(0, "underrun");
      for (int k = 0; k < 2; k++) begin
         nchk++;
         if (got_word(0, base, k, A_FB, 0) !== exp_data(fr, k, 1'b1, A_FB, A_SW, A_SLW)) begin
            nfail++;
            $display("FAIL underrun data frame %0d: got %h required %h", k,
                     got_word(0, base, k, A_FB, 0), exp_data(fr, k, 1'b1, A_FB, A_SW, A_SLW));
         end
      end
      nchk++;
      if (ur_a - ub != 1) begin
         nfail++; $display("FAIL underrun pulses: got %0d required 1", ur_a - ub);
      end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      nchk++;
      if (a_ucnt !== 16'd1) begin
         nfail++; $display("FAIL ucnt_after: got %0d required 1", a_ucnt);
      end
`endif
   endtask

   task automatic test_back_to_back();
      frm_t fr[$];
      bit   ok, allok, stuck;
      int   base, t;
      reset_a();
      a_mode = 1'b1;
      for (int i = 0; i < 5; i++) fr.push_back(rnd_frame(32));
      allok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_a(fr[i], ok);
         allok &= ok;
      end
      nchk++;
      if (!allok) begin nfail++; $display("FAIL b2b first4: accepted 0 required 1"); end
      base = cap_a.size();
      @(negedge clk);
      a_s_data  = fr[4][31:0];
      a_s_valid = 1'b1;
      nchk++;
      if (a_s_ready !== 1'b0) begin
         nfail++; $display("FAIL b2b full_ready: got %b required 0", a_s_ready);
      end
      stuck = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (a_s_ready !== 1'b0) stuck = 1'b1;
      end
      nchk++;
      if (stuck) begin nfail++; $display("FAIL b2b held_ready: got 1 required 0"); end
      a_enable = 1'b1;
      t = 0;
      @(negedge clk);
      while (!a_s_ready && t < 100) begin @(negedge clk); t++; end
      nchk++;
      if (!a_s_ready) begin nfail++; $display("FAIL b2b fifth_ready: got 0 required 1"); end
      @(posedge clk);
      #1 a_s_valid = 1'b0;
      wait_caps(0, base + 5*A_FB, "b2b");
      a_enable = 1'b0;
      wait_idle(0, "b2b");
      for (int k = 0; k < 5; k++) begin
         nchk++;
         if (got_word(0, base, k, A_FB, 0) !== exp_data(fr, k, 1'b1, A_FB, A_SW, A_SLW)) begin
            nfail++;
            $display("FAIL b2b data frame %0d: got %h required %h", k,
                     got_word(0, base, k, A_FB, 0), exp_data(fr, k, 1'b1, A_FB, A_SW, A_SLW));
         end
      end
   endtask

   task automatic test_tdm();
      frm_t fr[$];
      bit   ok;
      int   base;
      logic lj;
      for (int m = 0; m < 2; m++) begin
         lj = (m == 0);
         reset_b();
         b_mode = lj;
         fr.delete();
         for (int i = 0; i < 2; i++) begin
            fr.push_back(rnd_frame(48));
            push_b(fr[i], ok);
         end
         base = cap_b.size();
         @(negedge clk);
         b_enable = 1'b1;
         wait_caps(1, base + 2*B_FB, "tdm");
         b_enable = 1'b0;
         wait_idle(1, "tdm");
         for (int k = 0; k < 2; k++) begin
            nchk++;
            if (got_word(1, base, k, B_FB, 0) !== exp_data(fr, k, lj, B_FB, B_SW, B_SLW)) begin
               nfail++;
               $display("FAIL tdm lj=%0d data frame %0d: got %h required %h", lj, k,
                        got_word(1, base, k, B_FB, 0), exp_data(fr, k, lj, B_FB, B_SW, B_SLW));
            end
            nchk++;
            if (got_word(1, base, k, B_FB, 1) !== exp_lr(lj, B_NCH, B_FB, B_SLW)) begin
               nfail++;
               $display("FAIL tdm lj=%0d lrclk frame %0d: got %h required %h", lj, k,
                        got_word(1, base, k, B_FB, 1), exp_lr(lj, B_NCH, B_FB, B_SLW));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base, ub;
      reset_a();
      a_mode = 1'b1;
      push_a(rnd_frame(32), ok);
      push_a(rnd_frame(32), ok);
      base = cap_a.size();
      @(negedge clk);
      a_enable = 1'b1;
      wait_caps(0, base + 10, "reset_mid");
      @(negedge clk);
      a_reset  = 1'b1;
      a_enable = 1'b0;
      @(negedge clk);
      nchk++;
      if ({a_bclk, a_lrclk, a_sdata, a_busy, a_s_ready} !== 5'b0) begin
         nfail++;
         $display("FAIL reset_mid outs: got %b required 00000",
                  {a_bclk, a_lrclk, a_sdata, a_busy, a_s_ready});
      end
      a_reset = 1'b0;
      @(negedge clk);
      nchk++;
      if ({a_s_ready, a_busy} !== 2'b10) begin
         nfail++;
         $display("FAIL reset_mid release: ready/busy %b required 10", {a_s_ready, a_busy});
      end
      base = cap_a.size();
      ub   = ur_a;
      a_enable = 1'b1;
      wait_caps(0, base + A_FB, "reset_mid");
      a_enable = 1'b0;
      wait_idle(0, "reset_mid");
      nchk++;
      if (got_word(0, base, 0, A_FB, 0) !== 64'd0 || ur_a - ub != 1) begin
         nfail++;
         $display("FAIL reset_mid fifo_empty: data %h underruns %0d required 0 and 1",
                  got_word(0, base, 0, A_FB, 0), ur_a - ub);
      end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      nchk++;
      if (a_ucnt !== 16'd1) begin
         nfail++; $display("FAIL reset_mid ucnt: got %0d required 1", a_ucnt);
      end
`endif
   endtask

   initial begin
      a_reset = 1'b1; a_enable = 1'b0; a_mode = 1'b0;
      a_s_valid = 1'b0; a_s_data = '0;
      b_reset = 1'b1; b_enable = 1'b0; b_mode = 1'b0;
      b_s_valid = 1'b0; b_s_data = '0;
      test_reset();
      test_lj();
      test_philips();
      test_underrun();
      test_back_to_back();
      test_tdm();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
